// File: rtl/frame_head_pkg.sv
// Shared constants for the frame header builder: header word positions and
// parameter legality checks used at elaboration time.
package frame_head_pkg;

  // Header word positions
  localparam int IDX_SYNC  = 0;
  localparam int IDX_CNT   = 1;
  localparam int IDX_W     = 2;
  localparam int IDX_H     = 3;
  localparam int IDX_USER0 = 4;
  localparam int IDX_PAD0  = 8;

  // Legal parameter ranges
  localparam int DW_MIN = 8;
  localparam int DW_MAX = 32;
  localparam int HEAD_LENGTH_MIN = 9;
  localparam int HEAD_LENGTH_MAX = 256;

  function automatic bit dw_legal(input int dw);
    return (dw >= DW_MIN) && (dw <= DW_MAX);
  endfunction

  function automatic bit head_length_legal(input int hl);
    return (hl >= HEAD_LENGTH_MIN) && (hl <= HEAD_LENGTH_MAX);
  endfunction

endpackage

// File: rtl/frame_head_csum.sv
// Running modulo-2^DW sum of header words. A clear restarts the sum and may
// load the first word in the same cycle so the window's first word counts.
module frame_head_csum #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_add,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_sum
);

  logic [DW-1:0] sum_reg;

  // Accumulate added words; clear (optionally seeding with data) on request
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum_reg <= '0;
    end else if (i_clr) begin
      sum_reg <= i_add ? i_data : '0;
    end else if (i_add) begin
      sum_reg <= sum_reg + i_data;
    end
  end

  assign o_sum = sum_reg;

endmodule

// File: rtl/frame_header_builder.sv
// Frame header builder: emits a fixed-format header (sync, frame count,
// image size, user words, padding) one word per cycle while i_head_vld is
// high, one cycle behind the request. Counts windows and flags windows whose
// length differs from HEAD_LENGTH.
// Optional build macro FRAME_HEAD_CHECKSUM_EN: the last header word carries
// the modulo-2^DW sum of the preceding words instead of the pad word.
import frame_head_pkg::*;

module frame_header_builder #(
  parameter int          DW          = 16,
  parameter int          HEAD_LENGTH = 32,
  parameter logic [31:0] SYNC_WORD   = 32'h0000_BB66,
  parameter logic [31:0] PAD_WORD    = 32'h0000_FFFF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [DW-1:0]   i_img_w,
  input  logic [DW-1:0]   i_img_h,
  input  logic [4*DW-1:0] i_user,
  input  logic            i_head_vld,
  output logic [DW-1:0]   o_head,
  output logic            o_head_vld,
  output logic [DW-1:0]   o_frame_cnt,
  output logic            o_len_err
);

  // Index must hold HEAD_LENGTH itself so an overlong window can saturate there
  localparam int IW = $clog2(HEAD_LENGTH + 1);

  localparam logic [DW-1:0] SYNC_W = SYNC_WORD[DW-1:0];
  localparam logic [DW-1:0] PAD_W  = PAD_WORD[DW-1:0];

  localparam logic [IW-1:0] K_SYNC  = IW'(IDX_SYNC);
  localparam logic [IW-1:0] K_CNT   = IW'(IDX_CNT);
  localparam logic [IW-1:0] K_W     = IW'(IDX_W);
  localparam logic [IW-1:0] K_H     = IW'(IDX_H);
  localparam logic [IW-1:0] K_USER0 = IW'(IDX_USER0);
  localparam logic [IW-1:0] K_PAD0  = IW'(IDX_PAD0);
  localparam logic [IW-1:0] K_FULL  = IW'(HEAD_LENGTH);

  generate
    if (!dw_legal(DW) || !head_length_legal(HEAD_LENGTH)) begin : g_bad_params
      $error("frame_header_builder: DW must be 8..32 and HEAD_LENGTH 9..256");
    end
  endgenerate

  // Registered state
  logic            head_vld_reg;
  logic [DW-1:0]   head_reg;
  logic            len_err_reg;
  logic [DW-1:0]   frame_cnt_reg;
  logic [IW-1:0]   idx_reg;
  logic            over_reg;
  logic [DW-1:0]   snap_cnt_reg;
  logic [DW-1:0]   snap_w_reg;
  logic [DW-1:0]   snap_h_reg;
  logic [4*DW-1:0] snap_user_reg;

  // Next-state values
  logic            win_start;
  logic            win_end;
  logic [IW-1:0]   cur_idx;
  logic [IW-1:0]   idx_next;
  logic            over_next;
  logic [DW-1:0]   word_next;
  logic [DW-1:0]   head_next;
  logic            len_err_next;
  logic [DW-1:0]   frame_cnt_next;

  logic [DW-1:0]   user_words [4];

  // Split the snapshotted user bus into individual words
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_user_words
      assign user_words[gi] = snap_user_reg[gi*DW +: DW];
    end
  endgenerate

  // Window edges are seen against the previous cycle's request, which is
  // exactly the registered output qualifier; reset clears it so a request
  // held through reset release starts a fresh window.
  assign win_start = i_head_vld && !head_vld_reg;
  assign win_end   = !i_head_vld && head_vld_reg;
  assign cur_idx   = win_start ? '0 : idx_reg;

`ifdef FRAME_HEAD_CHECKSUM_EN
  localparam logic [IW-1:0] K_LAST     = IW'(HEAD_LENGTH - 1);
  localparam logic [IW-1:0] K_CSUM_END = IW'(HEAD_LENGTH - 2);

  logic          csum_add;
  logic [DW-1:0] csum_sum;

  // Only words ahead of the checksum slot are summed
  assign csum_add = i_head_vld && (cur_idx <= K_CSUM_END);

  frame_head_csum #(
    .DW(DW)
  ) u_csum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (win_start),
    .i_add   (csum_add),
    .i_data  (word_next),
    .o_sum   (csum_sum)
  );
`endif

  // Select the header word for the current index
  always_comb begin
    word_next = PAD_W;
    if (cur_idx == K_SYNC) begin
      word_next = SYNC_W;
    end else if (cur_idx == K_CNT) begin
      word_next = snap_cnt_reg;
    end else if (cur_idx == K_W) begin
      word_next = snap_w_reg;
    end else if (cur_idx == K_H) begin
      word_next = snap_h_reg;
    end else if ((cur_idx >= K_USER0) && (cur_idx < K_PAD0)) begin
      word_next = user_words[cur_idx[1:0]];
`ifdef FRAME_HEAD_CHECKSUM_EN
    end else if (cur_idx == K_LAST) begin
      word_next = csum_sum;
`endif
    end
  end

  // Index advance, overlong tracking, window-end bookkeeping
  always_comb begin
    head_next      = i_head_vld ? word_next : '0;
    idx_next       = idx_reg;
    over_next      = over_reg;
    len_err_next   = 1'b0;
    frame_cnt_next = frame_cnt_reg;

    if (i_head_vld) begin
      idx_next = (cur_idx == K_FULL) ? K_FULL : cur_idx + IW'(1);
    end

    // Saturated index cannot tell HEAD_LENGTH from longer; this flag can
    if (win_start) begin
      over_next = 1'b0;
    end else if (i_head_vld && (cur_idx == K_FULL)) begin
      over_next = 1'b1;
    end

    if (win_end) begin
      frame_cnt_next = frame_cnt_reg + DW'(1);
      len_err_next   = (idx_reg != K_FULL) || over_reg;
    end
  end

  // Output, counter and index registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_vld_reg  <= 1'b0;
      head_reg      <= '0;
      len_err_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      idx_reg       <= '0;
      over_reg      <= 1'b0;
    end else begin
      head_vld_reg  <= i_head_vld;
      head_reg      <= head_next;
      len_err_reg   <= len_err_next;
      frame_cnt_reg <= frame_cnt_next;
      idx_reg       <= idx_next;
      over_reg      <= over_next;
    end
  end

  // Freeze header fields at window start so mid-window input changes are ignored
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      snap_cnt_reg  <= '0;
      snap_w_reg    <= '0;
      snap_h_reg    <= '0;
      snap_user_reg <= '0;
    end else if (win_start) begin
      snap_cnt_reg  <= frame_cnt_reg;
      snap_w_reg    <= i_img_w;
      snap_h_reg    <= i_img_h;
      snap_user_reg <= i_user;
    end
  end

  assign o_head      = head_reg;
  assign o_head_vld  = head_vld_reg;
  assign o_frame_cnt = frame_cnt_reg;
  assign o_len_err   = len_err_reg;

endmodule

// File: tb/tb_frame_header_builder.sv
// Directed self-checking bench for frame_header_builder: default instance
// (DW=16, HEAD_LENGTH=32) plus a DW=8, HEAD_LENGTH=9 instance for wrap.
module tb_frame_header_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] img_w = '0;
  logic [15:0] img_h = '0;
  logic [63:0] user_in = '0;
  logic        head_vld = 1'b0;
  logic [15:0] o_head;
  logic        o_head_vld;
  logic [15:0] o_frame_cnt;
  logic        o_len_err;

  logic [7:0]  w8 = 8'h12;
  logic [7:0]  h8 = 8'h34;
  logic [31:0] user8 = '0;
  logic        vld8 = 1'b0;
  logic [7:0]  head8;
  logic        head_vld8;
  logic [7:0]  cnt8;
  logic        err8;

  int errors = 0;
  int checks = 0;

  logic [15:0] cap_head [0:63];
  logic        cap_vld  [0:63];
  logic        cap_err  [0:63];
  logic [15:0] end_head;
  logic        end_vld;
  logic        end_err;
  logic [15:0] end_cnt;
  logic        post_err;
  int          err_pulses;

  always #5 clk = ~clk;

  frame_header_builder dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_img_w     (img_w),
    .i_img_h     (img_h),
    .i_user      (user_in),
    .i_head_vld  (head_vld),
    .o_head      (o_head),
    .o_head_vld  (o_head_vld),
    .o_frame_cnt (o_frame_cnt),
    .o_len_err   (o_len_err)
  );

  frame_header_builder #(.DW(8), .HEAD_LENGTH(9)) dut8 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_img_w     (w8),
    .i_img_h     (h8),
    .i_user      (user8),
    .i_head_vld  (vld8),
    .o_head      (head8),
    .o_head_vld  (head_vld8),
    .o_frame_cnt (cnt8),
    .o_len_err   (err8)
  );

  // Reference header map for the default instance (words other than 31)
  function automatic logic [15:0] base_word(input int k, input logic [15:0] cnt,
                                            input logic [15:0] w, input logic [15:0] h,
                                            input logic [63:0] user);
    if (k == 0) return 16'hBB66;
    if (k == 1) return cnt;
    if (k == 2) return w;
    if (k == 3) return h;
    if (k >= 4 && k <= 7) return user[(k-4)*16 +: 16];
    return 16'hFFFF;
  endfunction

  function automatic logic [15:0] exp_word(input int k, input logic [15:0] cnt,
                                           input logic [15:0] w, input logic [15:0] h,
                                           input logic [63:0] user);
    logic [15:0] s;
    if (k != 31) return base_word(k, cnt, w, h, user);
`ifdef FRAME_HEAD_CHECKSUM_EN
    s = '0;
    for (int j = 0; j < 31; j++) s = s + base_word(j, cnt, w, h, user);
`else
    s = 16'hFFFF;
`endif
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    head_vld = 1'b0;
    vld8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive one window on the default instance and capture what comes back
  task automatic drive_window(input int len, input logic [15:0] w, input logic [15:0] h,
                              input logic [63:0] user, input bit scramble);
    img_w = w;
    img_h = h;
    user_in = user;
    for (int i = 0; i < len; i++) begin
      if (scramble && i > 0) begin
        img_w = w ^ 16'h5A5A ^ 16'(i);
        img_h = ~h;
        user_in = ~user ^ {4{16'(i)}};
      end
      head_vld = 1'b1;
      @(posedge clk);
      #1;
      cap_head[i] = o_head;
      cap_vld[i] = o_head_vld;
      cap_err[i] = o_len_err;
    end
    head_vld = 1'b0;
    @(posedge clk);
    #1;
    end_head = o_head;
    end_vld = o_head_vld;
    end_err = o_len_err;
    end_cnt = o_frame_cnt;
    @(posedge clk);
    #1;
    post_err = o_len_err;
    err_pulses = int'(end_err) + int'(post_err);
    for (int i = 0; i < len; i++) err_pulses += int'(cap_err[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    head_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_head !== 16'h0) begin errors++; $display("FAIL reset_head got=%h exp=0000", o_head); end
    checks++; if (o_head_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", o_head_vld); end
    checks++; if (o_frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", o_frame_cnt); end
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got=%b exp=0", o_len_err); end
    checks++; if (cnt8 !== 8'h0) begin errors++; $display("FAIL reset_cnt8 got=%h exp=00", cnt8); end
    head_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("test_reset done: head=%h vld=%b cnt=%h", o_head, o_head_vld, o_frame_cnt);
  endtask

  task automatic test_nominal();
    drive_window(32, 16'd640, 16'd512, 64'h0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap_head[i] !== exp_word(i, 16'h0, 16'd640, 16'd512, 64'h0) || cap_vld[i] !== 1'b1) begin
        errors++;
        $display("FAIL nominal_word[%0d] got=%h/%b exp=%h/1", i, cap_head[i], cap_vld[i],
                 exp_word(i, 16'h0, 16'd640, 16'd512, 64'h0));
      end
    end
    checks++; if (end_vld !== 1'b0 || end_head !== 16'h0) begin errors++; $display("FAIL nominal_idle got=%h/%b exp=0000/0", end_head, end_vld); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL nominal_len_err pulses=%0d exp=0", err_pulses); end
    checks++; if (end_cnt !== 16'd1) begin errors++; $display("FAIL nominal_cnt got=%h exp=0001", end_cnt); end
    $display("test_nominal: 32 words, last=%h cnt=%h", cap_head[31], end_cnt);
  endtask

  task automatic test_three_windows();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      drive_window(32, 16'h0100 + 16'(n), 16'h0200, 64'h1111_2222_3333_4444, 1'b0);
      checks++;
      if (cap_head[1] !== 16'(n)) begin
        errors++;
        $display("FAIL three_word1[%0d] got=%h exp=%h", n, cap_head[1], 16'(n));
      end
      checks++;
      if (cap_head[2] !== 16'h0100 + 16'(n) || cap_head[7] !== 16'h1111) begin
        errors++;
        $display("FAIL three_fields[%0d] got=%h,%h exp=%h,1111", n, cap_head[2], cap_head[7], 16'h0100 + 16'(n));
      end
      $display("test_three_windows: window %0d word1=%h", n, cap_head[1]);
    end
    checks++; if (end_cnt !== 16'd3) begin errors++; $display("FAIL three_cnt got=%h exp=0003", end_cnt); end
  endtask

  task automatic test_short_window();
    drive_window(10, 16'h0AAA, 16'h0BBB, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap_head[i] !== exp_word(i, 16'd3, 16'h0AAA, 16'h0BBB, 64'hDDDD_CCCC_BBBB_AAAA)) begin
        errors++;
        $display("FAIL short_word[%0d] got=%h exp=%h", i, cap_head[i],
                 exp_word(i, 16'd3, 16'h0AAA, 16'h0BBB, 64'hDDDD_CCCC_BBBB_AAAA));
      end
    end
    checks++; if (end_vld !== 1'b0) begin errors++; $display("FAIL short_stop got=%b exp=0", end_vld); end
    checks++; if (end_err !== 1'b1 || err_pulses != 1) begin errors++; $display("FAIL short_len_err got=%b pulses=%0d exp=1", end_err, err_pulses); end
    checks++; if (end_cnt !== 16'd4) begin errors++; $display("FAIL short_cnt got=%h exp=0004", end_cnt); end
    $display("test_short_window: 10 words, len_err=%b cnt=%h", end_err, end_cnt);
  endtask

  task automatic test_long_window();
    drive_window(40, 16'd1920, 16'd1080, 64'h0004_0003_0002_0001, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_head[i] !== exp_word(i, 16'd4, 16'd1920, 16'd1080, 64'h0004_0003_0002_0001) || cap_vld[i] !== 1'b1) begin
        errors++;
        $display("FAIL long_word[%0d] got=%h/%b exp=%h/1", i, cap_head[i], cap_vld[i],
                 exp_word(i, 16'd4, 16'd1920, 16'd1080, 64'h0004_0003_0002_0001));
      end
    end
    checks++; if (end_err !== 1'b1 || err_pulses != 1) begin errors++; $display("FAIL long_len_err got=%b pulses=%0d exp=1", end_err, err_pulses); end
    checks++; if (end_cnt !== 16'd5) begin errors++; $display("FAIL long_cnt got=%h exp=0005", end_cnt); end
    $display("test_long_window: 40 words, word39=%h len_err=%b", cap_head[39], end_err);
  endtask

  task automatic test_input_change();
    drive_window(32, 16'h1234, 16'h5678, 64'h9ABC_DEF0_1357_2468, 1'b1);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap_head[i] !== exp_word(i, 16'd5, 16'h1234, 16'h5678, 64'h9ABC_DEF0_1357_2468)) begin
        errors++;
        $display("FAIL change_word[%0d] got=%h exp=%h", i, cap_head[i],
                 exp_word(i, 16'd5, 16'h1234, 16'h5678, 64'h9ABC_DEF0_1357_2468));
      end
    end
    checks++; if (err_pulses != 0 || end_cnt !== 16'd6) begin errors++; $display("FAIL change_end pulses=%0d cnt=%h exp=0/0006", err_pulses, end_cnt); end
    $display("test_input_change: word2=%h word4=%h", cap_head[2], cap_head[4]);
  endtask

  task automatic test_reset_mid_window();
    logic [15:0] e;
    do_reset();
    img_w = 16'h0280;
    img_h = 16'h0200;
    user_in = 64'h0;
    head_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_head !== base_word(i, 16'h0, 16'h0280, 16'h0200, 64'h0)) begin
        errors++;
        $display("FAIL midrst_pre[%0d] got=%h exp=%h", i, o_head, base_word(i, 16'h0, 16'h0280, 16'h0200, 64'h0));
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_head !== 16'h0 || o_head_vld !== 1'b0 || o_len_err !== 1'b0 || o_frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midrst_clear got=%h/%b/%b/%h exp=0000/0/0/0000", o_head, o_head_vld, o_len_err, o_frame_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      e = exp_word(i, 16'h0, 16'h0280, 16'h0200, 64'h0);
      checks++;
      if (o_head !== e || o_head_vld !== 1'b1 || o_len_err !== 1'b0) begin
        errors++;
        $display("FAIL midrst_new[%0d] got=%h/%b/%b exp=%h/1/0", i, o_head, o_head_vld, o_len_err, e);
      end
    end
    head_vld = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_frame_cnt !== 16'd1 || o_len_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_end cnt=%h err=%b exp=0001/0", o_frame_cnt, o_len_err);
    end
    $display("test_reset_mid_window: cnt=%h", o_frame_cnt);
  endtask

  task automatic test_wrap8();
    int pulses8;
    logic [7:0] first0;
    logic [7:0] first8;
    logic [7:0] cnt_at_255;
    pulses8 = 0;
    first0 = '0;
    first8 = '0;
    cnt_at_255 = '0;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      vld8 = 1'b1;
      for (int i = 0; i < 9; i++) begin
        @(posedge clk);
        #1;
        if (n == 0 && i == 0) first0 = head8;
        if (n == 0 && i == 8) first8 = head8;
        pulses8 += int'(err8);
      end
      vld8 = 1'b0;
      @(posedge clk);
      #1;
      pulses8 += int'(err8);
      if (n == 254) cnt_at_255 = cnt8;
      @(posedge clk);
      #1;
      pulses8 += int'(err8);
    end
    checks++; if (first0 !== 8'h66) begin errors++; $display("FAIL wrap8_sync got=%h exp=66", first0); end
`ifdef FRAME_HEAD_CHECKSUM_EN
    checks++; if (first8 !== 8'hAC) begin errors++; $display("FAIL wrap8_last got=%h exp=ac", first8); end
`else
    checks++; if (first8 !== 8'hFF) begin errors++; $display("FAIL wrap8_last got=%h exp=ff", first8); end
`endif
    checks++; if (cnt_at_255 !== 8'hFF) begin errors++; $display("FAIL wrap8_cnt255 got=%h exp=ff", cnt_at_255); end
    checks++; if (cnt8 !== 8'h00) begin errors++; $display("FAIL wrap8_cnt got=%h exp=00", cnt8); end
    checks++; if (pulses8 != 0) begin errors++; $display("FAIL wrap8_len_err pulses=%0d exp=0", pulses8); end
    $display("test_wrap8: 256 windows, cnt8=%h", cnt8);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_three_windows();
    test_short_window();
    test_long_window();
    test_input_change();
    test_reset_mid_window();
    test_wrap8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
